// File: rtl/byte_unstrip_pkg.sv
// Shared symbol constants and framing FSM types for the striping / unstriping pair.
package byte_unstrip_pkg;

  localparam int LANES = 4;

  // Control symbol codes (carried with DK=0)
  localparam logic [7:0] STP = 8'hFB;
  localparam logic [7:0] SDP = 8'h5C;
  localparam logic [7:0] END = 8'hFD;
  localparam logic [7:0] EDB = 8'hFE;
  localparam logic [7:0] COM = 8'hBC;
  localparam logic [7:0] SKP = 8'h1C;
  localparam logic [7:0] IDL = 8'h7C;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } frame_state_t;

endpackage

// File: rtl/byte_unstrip_lane_group_fifo.sv
// Group buffer: DEPTH entries of one packed four-lane group each.
module lane_group_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 2,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_wr, do_rd;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage write; contents need no reset since empty masks the read side
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/byte_unstrip.sv
// Four-lane to byte-stream unstriper with inline packet framing checker.
module byte_unstrip
  import byte_unstrip_pkg::*;
#(
  parameter int BITS  = 8,
  parameter int DEPTH = 2
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [BITS-1:0] LANE0,
  input  logic [BITS-1:0] LANE1,
  input  logic [BITS-1:0] LANE2,
  input  logic [BITS-1:0] LANE3,
  input  logic            DK_0,
  input  logic            DK_1,
  input  logic            DK_2,
  input  logic            DK_3,
  input  logic            IN_VALID,
  output logic            IN_READY,
  output logic [BITS-1:0] D,
  output logic            DK,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic            PKT_ACTIVE,
  output logic            ERR_FRAME,
  output logic [7:0]      ERR_COUNT
);

  localparam int SW = BITS + 1;
  localparam int GW = LANES * SW;

  logic [GW-1:0] wr_grp, head_grp;
  logic [SW-1:0] slot [LANES];
  logic [SW-1:0] sym;
  logic [1:0]    lane;
  logic          full, empty;
  logic          push, xfer, pop;
  logic          is_start, is_end, is_frm;
  logic          frame_err;
  frame_state_t  state, state_nxt;

  // Lane 0 sits in the low slot; each slot is {kind, symbol}
  assign wr_grp = {DK_3, LANE3, DK_2, LANE2, DK_1, LANE1, DK_0, LANE0};

  assign IN_READY  = !full;
  assign OUT_VALID = !empty;
  assign push      = IN_VALID && IN_READY;
  assign xfer      = OUT_VALID && OUT_READY;
  assign pop       = xfer && (lane == 2'd3);

  lane_group_fifo #(.WIDTH(GW), .DEPTH(DEPTH)) u_fifo (
    .clk     (CLK),
    .rst     (RESET),
    .wr_en   (push),
    .wr_data (wr_grp),
    .rd_en   (pop),
    .rd_data (head_grp),
    .full    (full),
    .empty   (empty)
  );

  for (genvar i = 0; i < LANES; i++) begin : g_slot
    assign slot[i] = head_grp[i*SW +: SW];
  end

  assign sym = slot[lane];
  // Idle output is a blank data byte so nothing downstream sees a stray control
  assign D   = OUT_VALID ? sym[BITS-1:0] : '0;
  assign DK  = OUT_VALID ? sym[BITS]     : 1'b1;

  // Lane index walks the head group and wraps as the group is popped
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)     lane <= 2'd0;
    else if (xfer) lane <= lane + 2'd1;
  end

  assign is_start = (D == BITS'(STP)) || (D == BITS'(SDP));
  assign is_end   = (D == BITS'(END)) || (D == BITS'(EDB));
  assign is_frm   = is_start || is_end;

  // Framing decision for the byte transferring this cycle; any violation resyncs to IDLE
  always_comb begin
    state_nxt = state;
    frame_err = 1'b0;
    if (xfer && is_frm) begin
      if (DK) begin
        frame_err = 1'b1;
      end else if (is_start) begin
        if (state == IDLE && lane == 2'd0) state_nxt = PKT;
        else                               frame_err = 1'b1;
      end else begin
        if (state == PKT && lane == 2'd3) state_nxt = IDLE;
        else                              frame_err = 1'b1;
      end
      if (frame_err) state_nxt = IDLE;
    end
  end

  // Framing state, error pulse and saturating error count
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      ERR_FRAME <= 1'b0;
      ERR_COUNT <= 8'd0;
    end else begin
      state     <= state_nxt;
      ERR_FRAME <= frame_err;
      if (frame_err && ERR_COUNT != 8'hFF) ERR_COUNT <= ERR_COUNT + 8'd1;
    end
  end

  assign PKT_ACTIVE = (state == PKT);

endmodule

// File: doc/byte_unstrip.md
# byte_unstrip

Receive-side counterpart of the four-lane byte striper. Accepts one four-lane symbol group per handshake (LANE0..LANE3 plus per-lane DK flags), buffers up to DEPTH groups, and re-serializes them into a single byte stream, lane 0 first. Sits directly downstream of the striping stage and any lane transport, and feeds the packet receive logic. An inline framing checker tracks packet boundaries and flags violations of the striping rules.

## Interface
- BITS, 8: symbol width.
- DEPTH, 2: group buffer depth in four-lane groups; power of two, ≥2.
- CLK  in  1  single clock; all state updates on posedge.
- RESET  in  1  asynchronous, active-high; clears all state immediately.
- LANE0..LANE3  in  BITS each  lane symbols of one group.
- DK_0..DK_3  in  1 each  per-lane symbol kind: 0 = control symbol, 1 = data symbol.
- IN_VALID  in  1  group on LANE*/DK_* is valid.
- IN_READY  out  1  block can accept a group.
- D  out  BITS  serialized symbol.
- DK  out  1  kind of D; same encoding as DK_*.
- OUT_VALID  out  1  D/DK valid.
- OUT_READY  in  1  consumer accepts D/DK.
- PKT_ACTIVE  out  1  framing checker is inside a packet.
- ERR_FRAME  out  1  one-cycle framing-error pulse.
- ERR_COUNT  out  8  saturating framing-error count.

## Operation
- Control symbols: STP=8'hFB, SDP=8'h5C, END=8'hFD, EDB=8'hFE. The framing set is these four; COM, SKP and IDL are passed through without checks.
- Accept: a group is written when IN_VALID && IN_READY. IN_READY = (count < DEPTH). No write occurs when the buffer is full.
- Serializer: 2-bit lane index L selects the symbol from the head group. A byte transfers when OUT_VALID && OUT_READY. L advances on each transfer. A transfer at L=3 pops the head and wraps L to 0.
- OUT_VALID = (count > 0). When OUT_VALID=0, D=0 and DK=1.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Framing FSM (states IDLE and PKT), evaluated on each byte transfer:
  - IDLE, DK=0, D∈{STP,SDP}, L=0 → PKT.
  - PKT, DK=0, D∈{END,EDB}, L=3 → IDLE.
  - Error, next state IDLE:
    - any framing symbol at the wrong lane;
    - STP/SDP while in PKT;
    - END/EDB while in IDLE;
    - DK=1 with D in the framing set.
  - All other bytes: state unchanged, no error.
  - Bytes are always forwarded; errors never drop data.
- ERR_COUNT increments on each error and holds at 8'hFF.

## Timing
- Reset values:
  - IN_READY=1, OUT_VALID=0, D=0, DK=1;
  - PKT_ACTIVE=0, ERR_FRAME=0, ERR_COUNT=0;
  - L=0, buffer empty.
- Latency: a group accepted at edge N presents LANE0 on D in the cycle after N. Minimum 4 cycles per group at full OUT_READY throughput.
- D/DK/OUT_VALID are combinational from buffer state and L; there is no path from OUT_READY to OUT_VALID.
- ERR_FRAME is registered: it is high for exactly the cycle after the offending transfer edge. PKT_ACTIVE updates on the same edge as the transfer.
- OUT_READY low holds L, D and DK stable.
- RESET mid-group discards buffered groups and the partial group; the FSM returns to IDLE.

## Structure
- Shared package: symbol constants STP/SDP/END/EDB/COM/SKP/IDL, lane count 4, and the FSM state enum. The striping stage uses the same constants.
- Sub-module lane_group_fifo: DEPTH × (4·(BITS+1)) storage with count, full and empty. Width and depth are parameterized.
- Top level: lane index, output mux, framing FSM, error counter.

## Test plan
- Single packet:
  - Stimulus: group {FB/0, 11/1, 22/1, 33/1}, then {44/1, 55/1, 66/1, FD/0}, with OUT_READY=1.
  - Response: D = FB,11,22,33,44,55,66,FD on consecutive cycles. PKT_ACTIVE=1 from after FB until after FD. ERR_COUNT=0.
- Backpressure and full:
  - Stimulus: push 3 groups back-to-back with OUT_READY=0.
  - Response: IN_READY drops after 2 accepts. D holds lane0 of group 0. Releasing OUT_READY drains all 8 bytes in order, and IN_READY returns after the 4th byte.
- Misplaced framing:
  - Stimulus: STP/0 on lane 2.
  - Response: ERR_FRAME pulses once, ERR_COUNT=1, PKT_ACTIVE=0, and the byte is still output.
- Data-flagged framing:
  - Stimulus: FD/1 in any lane.
  - Response: error pulse, and the state returns to IDLE.
- Saturation:
  - Stimulus: 300 END/0 symbols sent while in IDLE.
  - Response: ERR_COUNT=8'hFF.
- Reset:
  - Stimulus: assert RESET while L=2 with 2 groups buffered.
  - Response: OUT_VALID=0 and IN_READY=1 immediately. After release, the next accepted group outputs from lane0.
